// File: rtl/vx_branch_resolver.sv
// vx_branch_resolver
//   Resolves committed branches against their prediction. On a mispredict
//   the block holds a pipeline flush for FLUSH_CYCLES cycles. It then offers
//   the corrected fetch PC until fetch accepts it.
//
//   Parameters
//     PC_BITS      width of all PC / target buses
//     FLUSH_CYCLES cycles branch_mispredict_flush is held (must be >= 1)
//
//   Ports
//     clk, reset                  clock, synchronous active-high reset
//     commit_valid/commit_ready   commit handshake from execute
//     commit_is_branch/_taken     resolved branch info
//     commit_target/_next_pc      resolved taken target / fall-through PC
//     pred_taken/pred_target      prediction made at fetch
//     decr                        pulse per accepted commit (inflight counter)
//     branch_mispredict_flush     pipeline flush request
//     redirect_valid/_ready/_pc   corrected PC handshake to fetch
//     perf_branches/_mispredicts  event counters
//
//   Build option
//     VX_BRANCH_RESOLVER_PERF_EN  when defined, enables the perf counters;
//                                 otherwise both perf outputs are tied to 0
module vx_branch_resolver #(
  parameter int unsigned PC_BITS      = 32,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               commit_valid,
  output logic               commit_ready,
  input  logic               commit_is_branch,
  input  logic               commit_taken,
  input  logic [PC_BITS-1:0] commit_target,
  input  logic [PC_BITS-1:0] commit_next_pc,
  input  logic               pred_taken,
  input  logic [PC_BITS-1:0] pred_target,
  output logic               decr,
  output logic               branch_mispredict_flush,
  output logic               redirect_valid,
  input  logic               redirect_ready,
  output logic [PC_BITS-1:0] redirect_pc,
  output logic [31:0]        perf_branches,
  output logic [31:0]        perf_mispredicts
);

  if (FLUSH_CYCLES < 1) begin : g_bad_flush_cycles
    $error("vx_branch_resolver: FLUSH_CYCLES must be at least 1");
  end

  localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    REDIRECT
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   flush_cnt;
  logic [PC_BITS-1:0] redirect_pc_q;
  logic               flush_q;
  logic               redirect_valid_q;
  logic               accept;
  logic               mispredict;

  // Accepting only in IDLE means accept already implies the IDLE state.
  // Masking with reset keeps decr quiet while reset is held.
  assign commit_ready = (state == IDLE) & ~reset;
  assign accept       = commit_valid & commit_ready;
  assign decr         = accept;

  assign mispredict = accept & commit_is_branch &
                      ((commit_taken != pred_taken) |
                       (commit_taken & pred_taken & (commit_target != pred_target)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      flush_cnt        <= '0;
      redirect_pc_q    <= '0;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mispredict) begin
            redirect_pc_q <= commit_taken ? commit_target : commit_next_pc;
            flush_cnt     <= FLUSH_LOAD;
            flush_q       <= 1'b1;
            state         <= FLUSH;
          end
        end
        FLUSH: begin
          if (flush_cnt == '0) begin
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b1;
            state            <= REDIRECT;
          end else begin
            flush_cnt <= flush_cnt - 1'b1;
          end
        end
        REDIRECT: begin
          if (redirect_ready) begin
            redirect_valid_q <= 1'b0;
            state            <= IDLE;
          end
        end
        default: begin
          flush_q          <= 1'b0;
          redirect_valid_q <= 1'b0;
          state            <= IDLE;
        end
      endcase
    end
  end

  assign branch_mispredict_flush = flush_q;
  assign redirect_valid          = redirect_valid_q;
  assign redirect_pc             = redirect_pc_q;

`ifdef VX_BRANCH_RESOLVER_PERF_EN
  logic [31:0] perf_br_q;
  logic [31:0] perf_mis_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_br_q  <= '0;
      perf_mis_q <= '0;
    end else begin
      if (accept & commit_is_branch) perf_br_q  <= perf_br_q + 32'd1;
      if (mispredict)                perf_mis_q <= perf_mis_q + 32'd1;
    end
  end

  assign perf_branches    = perf_br_q;
  assign perf_mispredicts = perf_mis_q;
`else
  assign perf_branches    = '0;
  assign perf_mispredicts = '0;
`endif

endmodule

// File: tb/tb_vx_branch_resolver.sv
// tb_vx_branch_resolver
//   Directed plus randomized stimulus for vx_branch_resolver.
//   The reference model keeps the cycle number of the outstanding mispredict.
//   Flush and redirect expectations follow from that timeline.
module tb_vx_branch_resolver;

  localparam int PCB = 32;
  localparam int FC  = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic           commit_valid;
  logic           commit_ready;
  logic           commit_is_branch;
  logic           commit_taken;
  logic [PCB-1:0] commit_target;
  logic [PCB-1:0] commit_next_pc;
  logic           pred_taken;
  logic [PCB-1:0] pred_target;
  logic           decr;
  logic           branch_mispredict_flush;
  logic           redirect_valid;
  logic           redirect_ready;
  logic [PCB-1:0] redirect_pc;
  logic [31:0]    perf_branches;
  logic [31:0]    perf_mispredicts;

  vx_branch_resolver #(.PC_BITS(PCB), .FLUSH_CYCLES(FC)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .commit_valid            (commit_valid),
    .commit_ready            (commit_ready),
    .commit_is_branch        (commit_is_branch),
    .commit_taken            (commit_taken),
    .commit_target           (commit_target),
    .commit_next_pc          (commit_next_pc),
    .pred_taken              (pred_taken),
    .pred_target             (pred_target),
    .decr                    (decr),
    .branch_mispredict_flush (branch_mispredict_flush),
    .redirect_valid          (redirect_valid),
    .redirect_ready          (redirect_ready),
    .redirect_pc             (redirect_pc),
    .perf_branches           (perf_branches),
    .perf_mispredicts        (perf_mispredicts)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;

  // Reference model: current cycle, cycle of outstanding mispredict (-1 none)
  int          t        = 0;
  int          mis_t    = -1;
  logic [31:0] pc_x     = '0;
  logic [31:0] m_br     = '0;
  logic [31:0] m_mis    = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, t);
    end
  endtask

  task automatic step(input bit rst, input bit cv, input bit br, input bit tk,
                      input bit pt, input logic [31:0] tgt, input logic [31:0] npc,
                      input logic [31:0] ptgt, input bit rr);
    bit          flush_e, redir_e, ready_e, decr_e, mis_e;
    logic [31:0] pb_e, pm_e;
    @(negedge clk);
    reset            = rst;
    commit_valid     = cv;
    commit_is_branch = br;
    commit_taken     = tk;
    pred_taken       = pt;
    commit_target    = tgt;
    commit_next_pc   = npc;
    pred_target      = ptgt;
    redirect_ready   = rr;
    #1;
    flush_e = (mis_t >= 0) && (t > mis_t) && (t <= mis_t + FC);
    redir_e = (mis_t >= 0) && (t > mis_t + FC);
    ready_e = !rst && !flush_e && !redir_e;
    decr_e  = cv && ready_e;
    mis_e   = decr_e && br && ((tk != pt) || (tk && pt && tgt != ptgt));
`ifdef VX_BRANCH_RESOLVER_PERF_EN
    pb_e = m_br;
    pm_e = m_mis;
`else
    pb_e = '0;
    pm_e = '0;
`endif
    chk("commit_ready", {31'd0, commit_ready}, {31'd0, ready_e});
    chk("decr", {31'd0, decr}, {31'd0, decr_e});
    chk("flush", {31'd0, branch_mispredict_flush}, {31'd0, flush_e});
    chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, redir_e});
    chk("redirect_pc", redirect_pc, pc_x);
    chk("perf_branches", perf_branches, pb_e);
    chk("perf_mispredicts", perf_mispredicts, pm_e);
    @(posedge clk);
    if (rst) begin
      mis_t = -1;
      pc_x  = '0;
      m_br  = '0;
      m_mis = '0;
    end else begin
      if (redir_e && rr) mis_t = -1;
      if (decr_e && br) m_br = m_br + 32'd1;
      if (mis_e) begin
        mis_t = t;
        pc_x  = tk ? tgt : npc;
        m_mis = m_mis + 32'd1;
      end
    end
    t++;
  endtask

  task automatic idle(input int n, input bit rr);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, rr);
  endtask

  initial begin
    // Bring the DUT out of an unknown state before any comparison.
    reset = 1'b1; commit_valid = 1'b0; commit_is_branch = 1'b0; commit_taken = 1'b0;
    pred_taken = 1'b0; commit_target = '0; commit_next_pc = '0; pred_target = '0;
    redirect_ready = 1'b0;
    repeat (2) @(posedge clk);
    t = 0;

    // Reset held with a pending commit: no ready, no decr.
    step(1, 1, 1, 1, 0, 32'h40, 32'h44, 32'h0, 0);
    idle(1, 0);

    // Three back-to-back non-branch commits.
    repeat (3) step(0, 1, 0, 0, 0, 32'h0, 32'h8, 32'h0, 0);
    idle(1, 0);

    // Correctly predicted taken branch.
    step(0, 1, 1, 1, 1, 32'h100, 32'h104, 32'h100, 0);
    idle(1, 0);

    // Direction mispredict (taken), fetch always ready.
    step(0, 1, 1, 1, 0, 32'h2000, 32'h1ff4, 32'h0, 1);
    idle(5, 1);

    // Direction mispredict (not taken), fetch stalls the redirect 5 cycles.
    step(0, 1, 1, 0, 1, 32'h5550, 32'h1004, 32'h5550, 0);
    idle(FC, 0);
    idle(5, 0);
    idle(2, 1);

    // Target mismatch with a non-branch commit queued through flush/redirect.
    step(0, 1, 1, 1, 1, 32'h300, 32'h2fc, 32'h304, 0);
    repeat (FC + 2) step(0, 1, 0, 0, 0, 32'h0, 32'h10, 32'h0, 0);
    step(0, 1, 0, 0, 0, 32'h0, 32'h10, 32'h0, 1);
    step(0, 1, 0, 0, 0, 32'h0, 32'h14, 32'h0, 0);

    // Mispredict queued behind a redirect is taken on the first IDLE cycle.
    step(0, 1, 1, 0, 1, 32'h700, 32'h604, 32'h700, 0);
    repeat (FC) step(0, 1, 1, 1, 0, 32'h900, 32'h804, 32'h0, 0);
    step(0, 1, 1, 1, 0, 32'h900, 32'h804, 32'h0, 1);
    step(0, 1, 1, 1, 0, 32'h900, 32'h804, 32'h0, 0);
    idle(FC + 2, 1);

    // Reset in the first flush cycle drops flush and the redirect.
    step(0, 1, 1, 1, 0, 32'hA00, 32'hB00, 32'h0, 1);
    step(1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 1);
    step(0, 1, 0, 0, 0, 32'h0, 32'h0, 32'h0, 1);
    idle(4, 1);

    // Randomized traffic. A small target pool makes matches and mismatches both common.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] pool [4];
      pool[0] = 32'h100; pool[1] = 32'h104; pool[2] = 32'h2000; pool[3] = 32'h3ffc;
      step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           pool[$urandom_range(0, 3)], 32'h1000 + 32'($urandom_range(0, 255)) * 4,
           pool[$urandom_range(0, 3)], $urandom_range(0, 2) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
